// File: rtl/ql_bus_pkg.sv
// Shared types and frame constants for the QL SDRAM bus arbiter.
package ql_bus_pkg;

  localparam int unsigned CNT_W     = 3;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BE_W      = 2;
  localparam int unsigned FRAME_LEN = 8;

  localparam logic [CNT_W-1:0] SLOT_A = 3'd0;
  localparam logic [CNT_W-1:0] SLOT_B = 3'd4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_MDV,
    OWN_CPU
  } owner_e;

  // Frame counter successor with wrap at the end of the frame.
  function automatic logic [CNT_W-1:0] frame_next(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ql_bus_pipe.sv
// Owner-tag delay line: tracks which requester each SDRAM command belongs to
// until its data returns RD_LAT clocks later.
module ql_bus_pipe
  import ql_bus_pkg::*;
#(
  parameter int unsigned RD_LAT = 3
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  owner_e tag_i,
  output owner_e done_o,
  output logic   cpu_busy_c,
  output logic   mdv_busy_c
);

  owner_e tag_q [RD_LAT];
  owner_e tag_d [RD_LAT];

  always_comb begin
    tag_d[0] = tag_i;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tag_q[i] <= OWN_NONE;
      end
    end else begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign done_o = tag_q[RD_LAT-1];

  // A requester is in flight while any stage still carries its tag.
  always_comb begin
    cpu_busy_c = 1'b0;
    mdv_busy_c = 1'b0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      if (tag_q[i] == OWN_CPU) cpu_busy_c = 1'b1;
      if (tag_q[i] == OWN_MDV) mdv_busy_c = 1'b1;
    end
  end

endmodule

// File: rtl/ql_bus_arbiter.sv
// Time-division arbiter sharing one SDRAM port between ZX8301 video, the CPU
// bridge and microdrive emulation; two command slots per 8-clock frame.
module ql_bus_arbiter
  import ql_bus_pkg::*;
#(
  parameter int unsigned RD_LAT = 3,
  parameter int unsigned AW     = 19
) (
  input  logic              clk_bus,
  input  logic              reset,
  input  logic              vid_rd,
  input  logic [AW-1:0]     vid_addr,
  output logic [DATA_W-1:0] vid_dout,
  output logic              video_cycle,
  input  logic              mdv_men,
  input  logic              mdv_req,
  input  logic              mdv_we,
  input  logic [AW-1:0]     mdv_addr,
  input  logic [DATA_W-1:0] mdv_wdata,
  output logic              mdv_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] mdv_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [BE_W-1:0]   ram_be,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              video_cycle_q, video_cycle_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [BE_W-1:0]   ram_be_q, ram_be_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              mdv_ack_q, mdv_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] mdv_rdata_q, mdv_rdata_d;
  logic [DATA_W-1:0] vid_dout_q, vid_dout_d;

  owner_e grant_c;
  owner_e done;
  logic   cpu_busy_c, mdv_busy_c;
  logic   cpu_elig_c, mdv_elig_c;

  ql_bus_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk_i      (clk_bus),
    .reset_i    (reset),
    .tag_i      (grant_c),
    .done_o     (done),
    .cpu_busy_c (cpu_busy_c),
    .mdv_busy_c (mdv_busy_c)
  );

  // Slot decision is made the clock before the slot so ram_cs lands on cnt 0/4.
  // The ack check gives a held request one clock to drop before re-arming.
  always_comb begin
    cnt_d         = frame_next(cnt_q);
    video_cycle_d = (cnt_d < SLOT_B);
    cpu_elig_c    = cpu_req && !cpu_busy_c && !cpu_ack_q;
    mdv_elig_c    = mdv_req && !mdv_busy_c && !mdv_ack_q;
    grant_c       = OWN_NONE;
    if (cnt_d == SLOT_A) begin
      if (vid_rd)                    grant_c = OWN_VID;
      else if (mdv_men && mdv_elig_c) grant_c = OWN_MDV;
      else if (cpu_elig_c)           grant_c = OWN_CPU;
    end else if (cnt_d == SLOT_B) begin
      if (cpu_elig_c)      grant_c = OWN_CPU;
      else if (mdv_elig_c) grant_c = OWN_MDV;
    end
  end

  // Command launch: address/data hold their last value between grants.
  always_comb begin
    ram_cs_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (grant_c)
      OWN_VID: begin
        ram_cs_d   = 1'b1;
        ram_we_d   = 1'b0;
        ram_be_d   = 2'b11;
        ram_addr_d = vid_addr;
      end
      OWN_MDV: begin
        ram_cs_d    = 1'b1;
        ram_we_d    = mdv_we;
        ram_be_d    = 2'b11;
        ram_addr_d  = mdv_addr;
        ram_wdata_d = mdv_wdata;
      end
      OWN_CPU: begin
        ram_cs_d    = 1'b1;
        ram_we_d    = cpu_we;
        ram_be_d    = cpu_be;
        ram_addr_d  = cpu_addr;
        ram_wdata_d = cpu_wdata;
      end
      default: ;
    endcase
  end

  // Completion routing: data and ack appear together in the cycle after return.
  always_comb begin
    cpu_ack_d   = 1'b0;
    mdv_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mdv_rdata_d = mdv_rdata_q;
    vid_dout_d  = vid_dout_q;
    case (done)
      OWN_CPU: begin
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = ram_dout;
      end
      OWN_MDV: begin
        mdv_ack_d   = 1'b1;
        mdv_rdata_d = ram_dout;
      end
      OWN_VID: vid_dout_d = ram_dout;
      default: ;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (reset) begin
      cnt_q         <= '0;
      video_cycle_q <= 1'b1;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_be_q      <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      mdv_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      mdv_rdata_q   <= '0;
      vid_dout_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      video_cycle_q <= video_cycle_d;
      ram_cs_q      <= ram_cs_d;
      ram_we_q      <= ram_we_d;
      ram_be_q      <= ram_be_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      cpu_ack_q     <= cpu_ack_d;
      mdv_ack_q     <= mdv_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      mdv_rdata_q   <= mdv_rdata_d;
      vid_dout_q    <= vid_dout_d;
    end
  end

  assign video_cycle = video_cycle_q;
  assign ram_cs      = ram_cs_q;
  assign ram_we      = ram_we_q;
  assign ram_be      = ram_be_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign mdv_ack     = mdv_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign mdv_rdata   = mdv_rdata_q;
  assign vid_dout    = vid_dout_q;

endmodule

// File: tb/tb_ql_bus_arbiter.sv
// Directed bench for ql_bus_arbiter with a fixed-latency SDRAM read model.
module tb_ql_bus_arbiter;

  localparam int unsigned AW = 19;

  logic          clk_bus = 1'b0;
  logic          reset;
  logic          vid_rd;
  logic [AW-1:0] vid_addr;
  logic [15:0]   vid_dout;
  logic          video_cycle;
  logic          mdv_men, mdv_req, mdv_we;
  logic [AW-1:0] mdv_addr;
  logic [15:0]   mdv_wdata;
  logic          mdv_ack;
  logic          cpu_req, cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic          cpu_ack;
  logic [15:0]   cpu_rdata, mdv_rdata;
  logic          ram_cs, ram_we;
  logic [1:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_dout;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  tcnt;
  logic        r1, r2;
  logic [15:0] mem_data;

  ql_bus_arbiter #(.RD_LAT(3), .AW(AW)) dut (
    .clk_bus(clk_bus), .reset(reset),
    .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_dout(vid_dout), .video_cycle(video_cycle),
    .mdv_men(mdv_men), .mdv_req(mdv_req), .mdv_we(mdv_we), .mdv_addr(mdv_addr),
    .mdv_wdata(mdv_wdata), .mdv_ack(mdv_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .mdv_rdata(mdv_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_dout(ram_dout)
  );

  always #5 clk_bus = ~clk_bus;

  // Reference frame position: 0 after reset, then free-running mod 8.
  always @(posedge clk_bus) tcnt <= reset ? 3'd0 : tcnt + 3'd1;

  // SDRAM model: data valid in the cycle two clocks after the ram_cs cycle.
  always @(posedge clk_bus) begin
    r1 <= ram_cs;
    r2 <= r1;
  end
  assign ram_dout = r2 ? mem_data : 16'hDEAD;

  task automatic step();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic wait_cnt(input logic [2:0] c);
    step();
    for (int i = 0; i < 8 && tcnt != c; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    checks++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_be !== 2'b00) begin failures++;
      $display("FAIL rst_cmd act=%b%b%b exp=0000", ram_cs, ram_we, ram_be); end
    checks++; if (ram_addr !== 19'h0 || ram_wdata !== 16'h0) begin failures++;
      $display("FAIL rst_addr act=%h/%h exp=0/0", ram_addr, ram_wdata); end
    checks++; if (cpu_ack !== 1'b0 || mdv_ack !== 1'b0) begin failures++;
      $display("FAIL rst_ack act=%b%b exp=00", cpu_ack, mdv_ack); end
    checks++; if (vid_dout !== 16'h0 || cpu_rdata !== 16'h0 || mdv_rdata !== 16'h0) begin failures++;
      $display("FAIL rst_data act=%h/%h/%h exp=0", vid_dout, cpu_rdata, mdv_rdata); end
    checks++; if (video_cycle !== 1'b1) begin failures++;
      $display("FAIL rst_vc act=%b exp=1", video_cycle); end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (video_cycle !== (tcnt < 3'd4)) begin failures++;
        $display("FAIL idle_vc cyc=%0d act=%b exp=%b", i, video_cycle, tcnt < 3'd4); end
      checks++; if (ram_cs !== 1'b0) begin failures++;
        $display("FAIL idle_cs cyc=%0d act=%b exp=0", i, ram_cs); end
      step();
    end
  endtask

  task automatic test_video();
    wait_cnt(3'd7);
    vid_rd = 1'b1; vid_addr = 19'h10000; mem_data = 16'hA5C3;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h10000 || ram_we !== 1'b0 || ram_be !== 2'b11) begin failures++;
      $display("FAIL vid_grant act=cs%b a%h we%b be%b exp=cs1 a10000 we0 be11", ram_cs, ram_addr, ram_we, ram_be); end
    vid_rd = 1'b0;
    step();
    checks++; if (ram_cs !== 1'b0) begin failures++;
      $display("FAIL vid_cs_one act=%b exp=0", ram_cs); end
    step();
    checks++; if (vid_dout !== 16'h0000) begin failures++;
      $display("FAIL vid_early act=%h exp=0000", vid_dout); end
    step();
    checks++; if (vid_dout !== 16'hA5C3 || video_cycle !== 1'b1) begin failures++;
      $display("FAIL vid_data act=%h vc%b exp=a5c3 vc1", vid_dout, video_cycle); end
    mem_data = 16'h1234;
    step();
    checks++; if (vid_dout !== 16'hA5C3 || video_cycle !== 1'b0) begin failures++;
      $display("FAIL vid_hold act=%h vc%b exp=a5c3 vc0", vid_dout, video_cycle); end
  endtask

  task automatic test_cpu_write();
    wait_cnt(3'd3);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b01; cpu_addr = 19'h14000; cpu_wdata = 16'h00FF;
    vid_rd = 1'b1; vid_addr = 19'h10000;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_be !== 2'b01 || ram_addr !== 19'h14000 || ram_wdata !== 16'h00FF) begin failures++;
      $display("FAIL cpuw_grant act=cs%b we%b be%b a%h d%h exp=cs1 we1 be01 a14000 d00ff", ram_cs, ram_we, ram_be, ram_addr, ram_wdata); end
    step(); step();
    checks++; if (cpu_ack !== 1'b0) begin failures++;
      $display("FAIL cpuw_early_ack act=%b exp=0", cpu_ack); end
    step();
    checks++; if (cpu_ack !== 1'b1) begin failures++;
      $display("FAIL cpuw_ack act=%b exp=1", cpu_ack); end
    step();
    checks++; if (cpu_ack !== 1'b0 || ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 19'h10000) begin failures++;
      $display("FAIL cpuw_no_regrant act=ack%b cs%b we%b a%h exp=ack0 cs1 we0 a10000", cpu_ack, ram_cs, ram_we, ram_addr); end
    cpu_req = 1'b0; vid_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    wait_cnt(3'd3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 19'h00123; mem_data = 16'h5A5A;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h00123) begin failures++;
      $display("FAIL b2b_grant act=cs%b a%h exp=cs1 a00123", ram_cs, ram_addr); end
    wait_cnt(3'd7);
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h5A5A) begin failures++;
      $display("FAIL b2b_read act=ack%b d%h exp=ack1 d5a5a", cpu_ack, cpu_rdata); end
    step();
    checks++; if (ram_cs !== 1'b0) begin failures++;
      $display("FAIL b2b_rearm_gap act=%b exp=0", ram_cs); end
    wait_cnt(3'd4);
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h00123) begin failures++;
      $display("FAIL b2b_regrant act=cs%b a%h exp=cs1 a00123", ram_cs, ram_addr); end
    cpu_req = 1'b0;
    wait_cnt(3'd7);
    checks++; if (cpu_ack !== 1'b1) begin failures++;
      $display("FAIL b2b_drop_after_grant act=%b exp=1", cpu_ack); end
  endtask

  task automatic test_mdv_cpu();
    wait_cnt(3'd7);
    vid_rd = 1'b0; mdv_men = 1'b1; mem_data = 16'hBEEF;
    mdv_req = 1'b1; mdv_we = 1'b0; mdv_addr = 19'h20000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 19'h00400;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h20000 || ram_be !== 2'b11) begin failures++;
      $display("FAIL men1_slota act=cs%b a%h be%b exp=cs1 a20000 be11", ram_cs, ram_addr, ram_be); end
    wait_cnt(3'd3);
    checks++; if (mdv_ack !== 1'b1 || mdv_rdata !== 16'hBEEF) begin failures++;
      $display("FAIL men1_mdv_ack act=ack%b d%h exp=ack1 dbeef", mdv_ack, mdv_rdata); end
    mdv_req = 1'b0;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h00400) begin failures++;
      $display("FAIL men1_slotb act=cs%b a%h exp=cs1 a00400", ram_cs, ram_addr); end
    wait_cnt(3'd7);
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hBEEF) begin failures++;
      $display("FAIL men1_cpu_ack act=ack%b d%h exp=ack1 dbeef", cpu_ack, cpu_rdata); end
    cpu_req = 1'b0;
    wait_cnt(3'd7);
    mdv_men = 1'b0;
    mdv_req = 1'b1; mdv_we = 1'b1; mdv_addr = 19'h20001; mdv_wdata = 16'h1111;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00401;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h00401) begin failures++;
      $display("FAIL men0_slota act=cs%b a%h exp=cs1 a00401", ram_cs, ram_addr); end
    wait_cnt(3'd3);
    checks++; if (cpu_ack !== 1'b1) begin failures++;
      $display("FAIL men0_cpu_ack act=%b exp=1", cpu_ack); end
    cpu_req = 1'b0;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h20001 || ram_we !== 1'b1 || ram_wdata !== 16'h1111) begin failures++;
      $display("FAIL men0_slotb act=cs%b a%h we%b d%h exp=cs1 a20001 we1 d1111", ram_cs, ram_addr, ram_we, ram_wdata); end
    wait_cnt(3'd7);
    checks++; if (mdv_ack !== 1'b1) begin failures++;
      $display("FAIL men0_mdv_ack act=%b exp=1", mdv_ack); end
    mdv_req = 1'b0;
  endtask

  task automatic test_reset_inflight();
    wait_cnt(3'd3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 19'h00777; mem_data = 16'h7777;
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h00777) begin failures++;
      $display("FAIL rif_grant act=cs%b a%h exp=cs1 a00777", ram_cs, ram_addr); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (ram_cs !== 1'b0 || cpu_ack !== 1'b0 || video_cycle !== 1'b1 || cpu_rdata !== 16'h0 || mdv_rdata !== 16'h0 || ram_addr !== 19'h0) begin failures++;
      $display("FAIL rif_state act=cs%b ack%b vc%b cd%h md%h a%h exp=cs0 ack0 vc1 0 0 0", ram_cs, cpu_ack, video_cycle, cpu_rdata, mdv_rdata, ram_addr); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (cpu_ack !== 1'b0 || ram_cs !== 1'b0) begin failures++;
        $display("FAIL rif_discard cyc=%0d act=ack%b cs%b exp=ack0 cs0", i, cpu_ack, ram_cs); end
    end
    step();
    checks++; if (ram_cs !== 1'b1 || ram_addr !== 19'h00777) begin failures++;
      $display("FAIL rif_regrant act=cs%b a%h exp=cs1 a00777", ram_cs, ram_addr); end
    cpu_req = 1'b0;
    step(); step(); step();
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h7777) begin failures++;
      $display("FAIL rif_ack act=ack%b d%h exp=ack1 d7777", cpu_ack, cpu_rdata); end
  endtask

  task automatic test_drop_before_grant();
    int cs_seen;
    int ack_seen;
    cs_seen = 0; ack_seen = 0;
    wait_cnt(3'd1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00055;
    step();
    cpu_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ram_cs === 1'b1) cs_seen++;
      if (cpu_ack === 1'b1) ack_seen++;
      step();
    end
    checks++; if (cs_seen != 0) begin failures++;
      $display("FAIL drop_no_grant act=%0d exp=0", cs_seen); end
    checks++; if (ack_seen != 0) begin failures++;
      $display("FAIL drop_no_ack act=%0d exp=0", ack_seen); end
  endtask

  initial begin
    reset = 1'b1;
    vid_rd = 1'b0; vid_addr = '0;
    mdv_men = 1'b0; mdv_req = 1'b0; mdv_we = 1'b0; mdv_addr = '0; mdv_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    mem_data = 16'h0000;
    test_reset();
    test_video();
    test_cpu_write();
    test_back_to_back();
    test_mdv_cpu();
    test_reset_inflight();
    test_drop_before_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
